// File: rtl/xgmii_tx_pacer.sv
// xgmii_tx_pacer: descriptor-driven 64-bit XGMII framer with IFG pacing.
// Define TX_STATS_EN to build the frame/byte/drop/underrun counters.
module xgmii_tx_pacer #(
  parameter int MIN_IFG = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 9600,
  parameter int LEN_W   = 16
) (
  input  logic             clk156,
  input  logic             rst,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [LEN_W-1:0] desc_len,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [63:0]      data_in,
  input  logic [3:0]       ifg_cfg,
  output logic [63:0]      xgmii_txd,
  output logic [7:0]       xgmii_txc,
  output logic             busy,
  output logic [31:0]      frame_cnt,
  output logic [47:0]      byte_cnt,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      urun_cnt
);

  localparam int WC_W = LEN_W - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TERM  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;
  localparam logic [2:0] S_IFG   = 3'd6;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

  logic [2:0]       state, state_nx;
  logic [LEN_W-1:0] len_q, len_nx;
  logic [WC_W-1:0]  rem, rem_nx;
  logic [3:0]       ifg_cnt, ifg_nx;
  logic [3:0]       ifg_load;
  logic             first_q, first_nx;
  logic [63:0]      txd_nx;
  logic [7:0]       txc_nx;
  logic [63:0]      last_d;
  logic [7:0]       last_c;
  logic             good_term, urun_evt, drop_evt;
  logic             bad_len;
  logic [WC_W-1:0]  desc_words;

  // Gap counter holds (gap - 1); the IFG state doubles as IDLE once it hits 0.
  assign ifg_load = ((ifg_cfg < 4'(MIN_IFG)) ? 4'(MIN_IFG) : ifg_cfg) - 4'd1;

  assign desc_ready = !rst && (ifg_cnt == 4'd0) &&
                      ((state == S_IDLE) || (state == S_IFG));
  assign data_ready = (state == S_DATA) ||
                      (((state == S_DRAIN) || (state == S_DROP)) && (rem != '0));
  assign busy = (state != S_IDLE);

  assign bad_len = (desc_len < LEN_W'(MIN_LEN)) || (desc_len > LEN_W'(MAX_LEN));
  assign desc_words = WC_W'(desc_len[LEN_W-1:3]) + WC_W'(desc_len[2:0] != 3'd0);

  always_comb begin
    last_d = IDLE_W;
    last_c = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len_q[2:0])) begin
        last_d[8*i +: 8] = data_in[8*i +: 8];
        last_c[i] = 1'b0;
      end else if (i == int'(len_q[2:0])) begin
        last_d[8*i +: 8] = 8'hFD;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    len_nx    = len_q;
    rem_nx    = rem;
    ifg_nx    = ifg_cnt;
    first_nx  = first_q;
    txd_nx    = IDLE_W;
    txc_nx    = 8'hFF;
    good_term = 1'b0;
    urun_evt  = 1'b0;
    drop_evt  = 1'b0;
    unique case (state)
      S_IDLE, S_IFG: begin
        if (ifg_cnt != 4'd0) begin
          ifg_nx = ifg_cnt - 4'd1;
        end else if (desc_valid) begin
          len_nx = desc_len;
          rem_nx = desc_words;
          if (bad_len) begin
            drop_evt = 1'b1;
            state_nx = S_DROP;
          end else begin
            state_nx = S_START;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (data_valid) begin
          txd_nx   = START_W;
          txc_nx   = 8'h01;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (!data_valid) begin
          txd_nx   = ERR_W;
          urun_evt = 1'b1;
          first_nx = 1'b1;
          state_nx = S_DRAIN;
        end else begin
          rem_nx = rem - WC_W'(1);
          txd_nx = data_in;
          txc_nx = 8'h00;
          if (rem == WC_W'(1)) begin
            if (len_q[2:0] == 3'd0) begin
              state_nx = S_TERM;
            end else begin
              txd_nx    = last_d;
              txc_nx    = last_c;
              good_term = 1'b1;
              ifg_nx    = ifg_load;
              state_nx  = S_IFG;
            end
          end
        end
      end
      S_TERM: begin
        txd_nx    = TERM_W;
        good_term = 1'b1;
        ifg_nx    = ifg_load;
        state_nx  = S_IFG;
      end
      S_DRAIN: begin
        first_nx = 1'b0;
        if (first_q) txd_nx = TERM_W;
        if (data_valid && (rem != '0)) rem_nx = rem - WC_W'(1);
        if ((rem == '0) || (data_valid && (rem == WC_W'(1)))) begin
          ifg_nx   = ifg_load;
          state_nx = S_IFG;
        end
      end
      S_DROP: begin
        if (data_valid && (rem != '0)) rem_nx = rem - WC_W'(1);
        if ((rem == '0) || (data_valid && (rem == WC_W'(1))))
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      rem       <= '0;
      ifg_cnt   <= 4'd0;
      first_q   <= 1'b0;
      xgmii_txd <= IDLE_W;
      xgmii_txc <= 8'hFF;
    end else begin
      state     <= state_nx;
      len_q     <= len_nx;
      rem       <= rem_nx;
      ifg_cnt   <= ifg_nx;
      first_q   <= first_nx;
      xgmii_txd <= txd_nx;
      xgmii_txc <= txc_nx;
    end
  end

`ifdef TX_STATS_EN
  logic [31:0] frame_q;
  logic [47:0] byte_q;
  logic [15:0] drop_q;
  logic [15:0] urun_q;

  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      byte_q  <= '0;
      drop_q  <= '0;
      urun_q  <= '0;
    end else begin
      if (good_term) begin
        frame_q <= frame_q + 32'd1;
        byte_q  <= byte_q + 48'(len_q);
      end
      if (drop_evt) drop_q <= drop_q + 16'd1;
      if (urun_evt) urun_q <= urun_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
  assign byte_cnt  = byte_q;
  assign drop_cnt  = drop_q;
  assign urun_cnt  = urun_q;
`else
  logic unused_stats;
  assign unused_stats = ^{good_term, urun_evt, drop_evt, len_q};
  assign frame_cnt = '0;
  assign byte_cnt  = '0;
  assign drop_cnt  = '0;
  assign urun_cnt  = '0;
`endif

endmodule

// File: tb/tb_xgmii_tx_pacer.sv
// tb_xgmii_tx_pacer: directed frames against a word-stream model.
`timescale 1ns/1ps
module tb_xgmii_tx_pacer;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
`ifdef TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk156 = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_len;
  logic        data_valid;
  logic        data_ready;
  logic [63:0] data_in;
  logic [3:0]  ifg_cfg;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy;
  logic [31:0] frame_cnt;
  logic [47:0] byte_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] urun_cnt;

  xgmii_tx_pacer dut (
    .clk156(clk156), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .ifg_cfg(ifg_cfg),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy),
    .frame_cnt(frame_cnt), .byte_cnt(byte_cnt),
    .drop_cnt(drop_cnt), .urun_cnt(urun_cnt)
  );

  always #3 clk156 = ~clk156;

  typedef struct packed {
    logic [63:0] w;
    logic [7:0]  hold;
  } dword_t;

  dword_t      data_q[$];
  logic [15:0] desc_q[$];
  logic [71:0] exp_q[$];
  logic [71:0] log_q[$];
  int          gaps[$];
  int          checks = 0;
  int          failures = 0;
  int          idle_run = 0;
  int          data_hs = 0;
  logic [31:0] m_frames;
  logic [47:0] m_bytes;
  logic [15:0] m_drops;
  logic [15:0] m_uruns;

  task automatic check(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: expected line words of one frame, from the framing rules.
  task automatic push_frame(input int len, input logic [7:0] seed,
                            input int ua);
    int wn;
    int n;
    logic [63:0] w;
    logic [71:0] e;
    dword_t d;
    wn = (len + 7) / 8;
    n = len % 8;
    if (n == 0) n = 8;
    for (int i = 0; i < wn; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = seed + 8'(8*i + j);
      d.w = w;
      d.hold = (i == ua) ? 8'd1 : 8'd0;
      data_q.push_back(d);
    end
    desc_q.push_back(16'(len));
    if (len < 64 || len > 9600) begin
      m_drops++;
      return;
    end
    exp_q.push_back({8'h01, START_W});
    for (int i = 0; i < wn; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = seed + 8'(8*i + j);
      if (i == ua) begin
        exp_q.push_back({8'hFF, ERR_W});
        exp_q.push_back({8'hFF, TERM_W});
        m_uruns++;
        return;
      end
      if (i < wn - 1 || n == 8) begin
        exp_q.push_back({8'h00, w});
      end else begin
        e = '0;
        for (int j = 0; j < 8; j++) begin
          if (j < n) e[8*j +: 8] = w[8*j +: 8];
          else if (j == n) begin e[8*j +: 8] = 8'hFD; e[64+j] = 1'b1; end
          else begin e[8*j +: 8] = 8'h07; e[64+j] = 1'b1; end
        end
        exp_q.push_back(e);
      end
    end
    if (n == 8) exp_q.push_back({8'hFF, TERM_W});
    m_frames++;
    m_bytes += 48'(len);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_frame_cnt"}, 72'(frame_cnt), STATS ? 72'(m_frames) : 72'd0);
    check({tag, "_byte_cnt"}, 72'(byte_cnt), STATS ? 72'(m_bytes) : 72'd0);
    check({tag, "_drop_cnt"}, 72'(drop_cnt), STATS ? 72'(m_drops) : 72'd0);
    check({tag, "_urun_cnt"}, 72'(urun_cnt), STATS ? 72'(m_uruns) : 72'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || desc_q.size() != 0 || data_q.size() != 0 ||
            busy) && n < 3000) begin
      @(negedge clk156);
      n++;
    end
    repeat (4) @(negedge clk156);
    check({tag, "_timeout"}, 72'(n >= 3000), 72'd0);
  endtask

  task automatic start_test();
    log_q.delete();
    gaps.delete();
  endtask

  initial begin : desc_drv
    logic [15:0] dummy;
    desc_valid = 1'b0;
    desc_len = '0;
    forever begin
      @(posedge clk156);
      if (desc_valid && desc_ready && desc_q.size() != 0) dummy = desc_q.pop_front();
      #1;
      if (desc_q.size() != 0) begin
        desc_valid = 1'b1;
        desc_len = desc_q[0];
      end else begin
        desc_valid = 1'b0;
      end
    end
  end

  initial begin : data_drv
    dword_t d;
    data_valid = 1'b0;
    data_in = '0;
    forever begin
      @(posedge clk156);
      if (data_valid && data_ready && data_q.size() != 0) begin
        d = data_q.pop_front();
        data_hs++;
      end
      #1;
      if (data_q.size() == 0) begin
        data_valid = 1'b0;
      end else if (data_q[0].hold != 8'd0) begin
        d = data_q[0];
        d.hold = d.hold - 8'd1;
        data_q[0] = d;
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b1;
        data_in = data_q[0].w;
      end
    end
  end

  initial begin : compare
    logic [71:0] obs;
    logic [71:0] e;
    forever begin
      @(negedge clk156);
      if (!rst) begin
        obs = {xgmii_txc, xgmii_txd};
        if (obs == {8'hFF, IDLE_W}) begin
          idle_run++;
        end else begin
          if (obs == {8'h01, START_W}) gaps.push_back(idle_run);
          idle_run = 0;
          log_q.push_back(obs);
          if (exp_q.size() == 0) begin
            check("unexpected_word", obs, {8'hFF, IDLE_W});
          end else begin
            e = exp_q.pop_front();
            check("stream", obs, e);
          end
        end
      end
    end
  end

  initial begin : main
    int base;
    int n;
    rst = 1'b1;
    ifg_cfg = 4'd0;
    m_frames = '0; m_bytes = '0; m_drops = '0; m_uruns = '0;
    repeat (3) @(negedge clk156);
    check("rst_txd", 72'(xgmii_txd), 72'(IDLE_W));
    check("rst_txc", 72'(xgmii_txc), 72'hFF);
    check("rst_desc_ready", 72'(desc_ready), 72'd0);
    check("rst_data_ready", 72'(data_ready), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check_cnts("rst");
    rst = 1'b0;
    @(negedge clk156);
    check("post_rst_desc_ready", 72'(desc_ready), 72'd1);

    // Two back-to-back 64-byte frames with minimum gap.
    start_test();
    push_frame(64, 8'h00, -1);
    push_frame(64, 8'h80, -1);
    wait_idle("t1");
    check("t1_words", 72'(log_q.size()), 72'd20);
    check("t1_start_lit", log_q[0], {8'h01, 64'hD5555555555555FB});
    check("t1_data0_lit", log_q[1], {8'h00, 64'h0706050403020100});
    check("t1_term_lit", log_q[9], {8'hFF, 64'h07070707070707FD});
    check("t1_gap", 72'(gaps[1]), 72'd2);
    check("t1_frames_lit", 72'(frame_cnt), STATS ? 72'd2 : 72'd0);
    check_cnts("t1");

    // 65 bytes: terminate folded into the ninth word.
    start_test();
    push_frame(65, 8'h00, -1);
    wait_idle("t2");
    check("t2_words", 72'(log_q.size()), 72'd10);
    check("t2_last_lit", log_q[9], {8'hFE, 64'h070707070707FD40});
    check_cnts("t2");

    // Runt dropped silently, then a 100-byte frame.
    start_test();
    push_frame(60, 8'hAA, -1);
    push_frame(100, 8'h10, -1);
    wait_idle("t3");
    check("t3_words", 72'(log_q.size()), 72'd14);
    check("t3_last_lit", log_q[13], {8'hF0, 64'h070707FD73727170});
    check_cnts("t3");

    // Underrun at word 5 of a 128-byte frame.
    start_test();
    push_frame(128, 8'h20, 5);
    wait_idle("t4");
    check("t4_words", 72'(log_q.size()), 72'd8);
    check("t4_word4_lit", log_q[5], {8'h00, 64'h4746454443424140});
    check("t4_err_lit", log_q[6], {8'hFF, ERR_W});
    check("t4_term_lit", log_q[7], {8'hFF, TERM_W});
    check_cnts("t4");

    // Programmed gap, then a request below the minimum.
    start_test();
    ifg_cfg = 4'd5;
    push_frame(64, 8'h33, -1);
    push_frame(64, 8'h44, -1);
    wait_idle("t5a");
    check("t5a_gap", 72'(gaps[1]), 72'd5);
    start_test();
    ifg_cfg = 4'd1;
    push_frame(64, 8'h55, -1);
    push_frame(72, 8'h66, -1);
    wait_idle("t5b");
    check("t5b_gap", 72'(gaps[1]), 72'd2);
    check_cnts("t5");

    // Reset in the middle of a 256-byte frame.
    start_test();
    ifg_cfg = 4'd0;
    base = data_hs;
    push_frame(256, 8'h01, -1);
    n = 0;
    while (data_hs < base + 3 && n < 500) begin
      @(negedge clk156);
      n++;
    end
    check("t6_wait_timeout", 72'(n >= 500), 72'd0);
    check("t6_busy_mid", 72'(busy), 72'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    data_q.delete();
    desc_q.delete();
    m_frames = '0; m_bytes = '0; m_drops = '0; m_uruns = '0;
    @(negedge clk156);
    check("t6_txd", 72'(xgmii_txd), 72'(IDLE_W));
    check("t6_txc", 72'(xgmii_txc), 72'hFF);
    check("t6_busy", 72'(busy), 72'd0);
    check("t6_frame_zero", 72'(frame_cnt), 72'd0);
    check("t6_byte_zero", 72'(byte_cnt), 72'd0);
    @(negedge clk156);
    rst = 1'b0;
    start_test();
    push_frame(64, 8'h77, -1);
    wait_idle("t6b");
    check("t6b_words", 72'(log_q.size()), 72'd10);
    check_cnts("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
